// File: rtl/cube_uc_pkg.sv
// Shared definitions for the scan-and-solve control unit: state encodings, error codes
// and the per-face reposition move table.
package cube_uc_pkg;

  localparam logic [3:0] ST_INICIAL     = 4'b0000;
  localparam logic [3:0] ST_PREPARA     = 4'b0001;
  localparam logic [3:0] ST_CAPTURA     = 4'b0010;
  localparam logic [3:0] ST_IDENTIFICA  = 4'b0011;
  localparam logic [3:0] ST_TRANSMITE   = 4'b0100;
  localparam logic [3:0] ST_REPOSICIONA = 4'b0101;
  localparam logic [3:0] ST_CONTA_REPOS = 4'b0110;
  localparam logic [3:0] ST_PROX_FACE   = 4'b0111;
  localparam logic [3:0] ST_RECEBE_MOV  = 4'b1000;
  localparam logic [3:0] ST_PREPARA_MOV = 4'b1001;
  localparam logic [3:0] ST_MOVIMENTA   = 4'b1010;
  localparam logic [3:0] ST_CONTA_MOV   = 4'b1011;
  localparam logic [3:0] ST_FIM         = 4'b1100;
  localparam logic [3:0] ST_ERRO        = 4'b1101;
  localparam logic [3:0] DB_ILEGAL      = 4'b1111;

  typedef enum logic [3:0] {
    Inicial     = ST_INICIAL,
    Prepara     = ST_PREPARA,
    Captura     = ST_CAPTURA,
    Identifica  = ST_IDENTIFICA,
    Transmite   = ST_TRANSMITE,
    Reposiciona = ST_REPOSICIONA,
    ContaRepos  = ST_CONTA_REPOS,
    ProxFace    = ST_PROX_FACE,
    RecebeMov   = ST_RECEBE_MOV,
    PreparaMov  = ST_PREPARA_MOV,
    Movimenta   = ST_MOVIMENTA,
    ContaMov    = ST_CONTA_MOV,
    Fim         = ST_FIM,
    Erro        = ST_ERRO
  } estado_t;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_TIMEOUT = 2'b01;
  localparam logic [1:0] ERR_RETRY   = 2'b10;

  // Entry k: reposition moves between scanning face k and face k+1.
  localparam int unsigned N_REPOS = 5;
  localparam logic [1:0] REPOS_MOVES [N_REPOS] = '{2'd1, 2'd1, 2'd1, 2'd2, 2'd1};

  function automatic logic [1:0] repos_moves(input logic [2:0] face);
    if (face < 3'(N_REPOS)) return REPOS_MOVES[face];
    return 2'd1;
  endfunction

endpackage

// File: rtl/uc_watchdog.sv
// Wait-state watchdog: counts up while not cleared and saturates at TIMEOUT_CYC-1,
// where o_expire stays high until the next clear.
module uc_watchdog #(
  parameter int unsigned TIMEOUT_CYC = 50_000_000,
  parameter int unsigned TO_W        = 26
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  output logic o_expire
);

  localparam logic [TO_W-1:0] LAST = TO_W'(TIMEOUT_CYC - 1);

  logic [TO_W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_cnt <= '0;
    end else if (r_cnt != LAST) begin
      r_cnt <= r_cnt + TO_W'(1);
    end
  end

  assign o_expire = (r_cnt == LAST);

endmodule

// File: rtl/cube_scan_solve_uc.sv
// Control unit for the Rubik's robot: scans N_FACES faces with retries and repositioning,
// then executes the host's solution. Moore outputs decoded from the registered state.
module cube_scan_solve_uc
  import cube_uc_pkg::*;
#(
  parameter int unsigned N_FACES     = 6,
  parameter int unsigned MOV_W       = 8,
  parameter int unsigned TIMEOUT_CYC = 50_000_000,
  parameter int unsigned TO_W        = 26,
  parameter int unsigned MAX_RETRY   = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             iniciar,
  input  logic             abortar,
  input  logic             imagem_recebida,
  input  logic             cores_identificadas,
  input  logic             cores_invalidas,
  input  logic             cores_transmitidas,
  input  logic             movimentos_recebidos,
  input  logic [MOV_W-1:0] num_movimentos,
  input  logic             fim_movimento,
  output logic             captura_imagem,
  output logic             identificar_cores,
  output logic             enviar_cores,
  output logic             receber_movimentos,
  output logic             aciona_movimento,
  output logic             tipo_movimento,
  output logic [2:0]       face_idx,
  output logic [MOV_W-1:0] move_idx,
  output logic             pronto,
  output logic             erro,
  output logic [1:0]       err_code,
  output logic [3:0]       db_estado
);

  localparam logic [2:0] LAST_FACE   = 3'(N_FACES - 1);
  localparam logic [1:0] RETRY_LIMIT = 2'(MAX_RETRY);

  estado_t          r_estado, w_estado_d;
  logic [2:0]       r_face, w_face_d;
  logic [MOV_W-1:0] r_move, w_move_d;
  logic [MOV_W-1:0] r_count, w_count_d;
  logic [1:0]       r_retry, w_retry_d;
  logic [1:0]       r_err, w_err_d;

  logic             w_espera;
  logic             w_aguardado;
  logic             w_expire;
  logic             w_wd_clear;
  logic [MOV_W-1:0] w_move_inc;

  assign w_move_inc = r_move + MOV_W'(1);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_estado <= Inicial;
      r_face   <= '0;
      r_move   <= '0;
      r_count  <= '0;
      r_retry  <= '0;
      r_err    <= ERR_NONE;
    end else begin
      r_estado <= w_estado_d;
      r_face   <= w_face_d;
      r_move   <= w_move_d;
      r_count  <= w_count_d;
      r_retry  <= w_retry_d;
      r_err    <= w_err_d;
    end
  end

  always_comb begin
    w_estado_d = r_estado;
    w_face_d   = r_face;
    w_move_d   = r_move;
    w_count_d  = r_count;
    w_retry_d  = r_retry;
    w_err_d    = r_err;
    if (abortar) begin
      w_estado_d = Inicial;
      w_face_d   = '0;
      w_move_d   = '0;
      w_count_d  = '0;
      w_retry_d  = '0;
      w_err_d    = ERR_NONE;
    end else begin
      case (r_estado)
        Inicial: if (iniciar) w_estado_d = Prepara;
        Prepara: begin
          w_face_d   = '0;
          w_move_d   = '0;
          w_retry_d  = '0;
          w_estado_d = Captura;
        end
        Captura: if (imagem_recebida) w_estado_d = Identifica;
        Identifica: begin
          if (cores_identificadas) begin
            if (!cores_invalidas) begin
              w_retry_d  = '0;
              w_estado_d = Transmite;
            end else if (r_retry < RETRY_LIMIT) begin
              w_retry_d  = r_retry + 2'd1;
              w_estado_d = Captura;
            end else begin
              w_err_d    = ERR_RETRY;
              w_estado_d = Erro;
            end
          end
        end
        Transmite: begin
          if (cores_transmitidas) begin
            if (r_face == LAST_FACE) begin
              w_estado_d = RecebeMov;
            end else begin
              w_move_d   = '0;
              w_estado_d = Reposiciona;
            end
          end
        end
        Reposiciona: if (fim_movimento) w_estado_d = ContaRepos;
        ContaRepos: begin
          w_move_d   = w_move_inc;
          w_estado_d = (w_move_inc == MOV_W'(repos_moves(r_face))) ? ProxFace : Reposiciona;
        end
        ProxFace: begin
          w_face_d   = r_face + 3'd1;
          w_estado_d = Captura;
        end
        RecebeMov: begin
          if (movimentos_recebidos) begin
            w_count_d  = num_movimentos;
            w_estado_d = PreparaMov;
          end
        end
        PreparaMov: begin
          w_move_d   = '0;
          w_estado_d = (r_count == '0) ? Fim : Movimenta;
        end
        Movimenta: if (fim_movimento) w_estado_d = ContaMov;
        ContaMov: begin
          if (w_move_inc == r_count) begin
            w_estado_d = Fim;
          end else begin
            w_move_d   = w_move_inc;
            w_estado_d = Movimenta;
          end
        end
        Fim: if (iniciar) w_estado_d = Prepara;
        Erro: begin
          if (iniciar) begin
            w_err_d    = ERR_NONE;
            w_estado_d = Prepara;
          end
        end
        default: begin
          w_estado_d = Inicial;
          w_face_d   = '0;
          w_move_d   = '0;
          w_count_d  = '0;
          w_retry_d  = '0;
          w_err_d    = ERR_NONE;
        end
      endcase
      // A timeout only fires when the awaited input did not arrive in the same cycle.
      if (w_espera && !w_aguardado && w_expire) begin
        w_err_d    = ERR_TIMEOUT;
        w_estado_d = Erro;
      end
    end
  end

  always_comb begin
    captura_imagem     = 1'b0;
    identificar_cores  = 1'b0;
    enviar_cores       = 1'b0;
    receber_movimentos = 1'b0;
    aciona_movimento   = 1'b0;
    tipo_movimento     = 1'b0;
    pronto             = 1'b0;
    erro               = 1'b0;
    w_espera           = 1'b0;
    w_aguardado        = 1'b0;
    db_estado          = r_estado;
    case (r_estado)
      Inicial, Prepara, ContaRepos, ProxFace, PreparaMov, ContaMov: ;
      Captura: begin
        captura_imagem = 1'b1;
        w_espera       = 1'b1;
        w_aguardado    = imagem_recebida;
      end
      Identifica: begin
        identificar_cores = 1'b1;
        w_espera          = 1'b1;
        w_aguardado       = cores_identificadas;
      end
      Transmite: begin
        enviar_cores = 1'b1;
        w_espera     = 1'b1;
        w_aguardado  = cores_transmitidas;
      end
      Reposiciona: begin
        aciona_movimento = 1'b1;
        w_espera         = 1'b1;
        w_aguardado      = fim_movimento;
      end
      RecebeMov: begin
        receber_movimentos = 1'b1;
        w_espera           = 1'b1;
        w_aguardado        = movimentos_recebidos;
      end
      Movimenta: begin
        aciona_movimento = 1'b1;
        tipo_movimento   = 1'b1;
        w_espera         = 1'b1;
        w_aguardado      = fim_movimento;
      end
      Fim:     pronto = 1'b1;
      Erro:    erro   = 1'b1;
      default: db_estado = DB_ILEGAL;
    endcase
  end

  assign w_wd_clear = !w_espera || (w_estado_d != r_estado);

  uc_watchdog #(
    .TIMEOUT_CYC(TIMEOUT_CYC),
    .TO_W       (TO_W)
  ) u_watchdog (
    .i_clk   (clock),
    .i_rst   (reset),
    .i_clear (w_wd_clear),
    .o_expire(w_expire)
  );

  assign face_idx = r_face;
  assign move_idx = r_move;
  assign err_code = r_err;

endmodule

// File: tb/tb_cube_scan_solve_uc.sv
// Directed bench for cube_scan_solve_uc: nominal scan/solve, retries, timeout, empty
// solution, abort and reset, with inputs driven and outputs sampled on the falling edge.
module tb_cube_scan_solve_uc;

  logic       clock = 1'b0;
  logic       reset, iniciar, abortar;
  logic       imagem_recebida, cores_identificadas, cores_invalidas, cores_transmitidas;
  logic       movimentos_recebidos, fim_movimento;
  logic [7:0] num_movimentos;
  logic       captura_imagem, identificar_cores, enviar_cores, receber_movimentos;
  logic       aciona_movimento, tipo_movimento, pronto, erro;
  logic [2:0] face_idx;
  logic [7:0] move_idx;
  logic [1:0] err_code;
  logic [3:0] db_estado;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] sol_q[$];

  always #5 clock = ~clock;

  cube_scan_solve_uc #(
    .N_FACES    (6),
    .MOV_W      (8),
    .TIMEOUT_CYC(16),
    .TO_W       (5),
    .MAX_RETRY  (2)
  ) dut (
    .clock               (clock),
    .reset               (reset),
    .iniciar             (iniciar),
    .abortar             (abortar),
    .imagem_recebida     (imagem_recebida),
    .cores_identificadas (cores_identificadas),
    .cores_invalidas     (cores_invalidas),
    .cores_transmitidas  (cores_transmitidas),
    .movimentos_recebidos(movimentos_recebidos),
    .num_movimentos      (num_movimentos),
    .fim_movimento       (fim_movimento),
    .captura_imagem      (captura_imagem),
    .identificar_cores   (identificar_cores),
    .enviar_cores        (enviar_cores),
    .receber_movimentos  (receber_movimentos),
    .aciona_movimento    (aciona_movimento),
    .tipo_movimento      (tipo_movimento),
    .face_idx            (face_idx),
    .move_idx            (move_idx),
    .pronto              (pronto),
    .erro                (erro),
    .err_code            (err_code),
    .db_estado           (db_estado)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [24:0] all_outs();
    return {captura_imagem, identificar_cores, enviar_cores, receber_movimentos,
            aciona_movimento, tipo_movimento, face_idx, move_idx, pronto, erro,
            err_code, db_estado};
  endfunction

  task automatic clear_acks();
    imagem_recebida      = 1'b0;
    cores_identificadas  = 1'b0;
    cores_invalidas      = 1'b0;
    cores_transmitidas   = 1'b0;
    movimentos_recebidos = 1'b0;
    fim_movimento        = 1'b0;
  endtask

  // Pulses iniciar, then acks every request one cycle after it appears. Stops on pronto,
  // erro, reaching stop_db, or issuing abortar at solution move abort_at.
  task automatic run_scan(input int inv_face, input int n_inv, input logic [7:0] nmov,
                          input int abort_at, input int stop_db,
                          output int caps, output int caps_inv, output int repos,
                          output bit ok);
    int  n_ident = 0;
    bit  done    = 1'b0;
    caps = 0; caps_inv = 0; repos = 0;
    sol_q.delete();
    num_movimentos = nmov;
    @(negedge clock); iniciar = 1'b1;
    @(negedge clock); iniciar = 1'b0;
    for (int cyc = 0; cyc < 400 && !done; cyc++) begin
      clear_acks();
      if (pronto || erro || int'(db_estado) == stop_db) begin
        done = 1'b1;
      end else begin
        if (captura_imagem) begin
          caps++;
          if (int'(face_idx) == inv_face) caps_inv++;
          imagem_recebida = 1'b1;
        end
        if (identificar_cores) begin
          cores_identificadas = 1'b1;
          if (int'(face_idx) == inv_face && n_ident < n_inv) begin
            cores_invalidas = 1'b1;
            n_ident++;
          end
        end
        if (enviar_cores) cores_transmitidas = 1'b1;
        if (receber_movimentos) movimentos_recebidos = 1'b1;
        if (aciona_movimento && !tipo_movimento) begin
          repos++;
          fim_movimento = 1'b1;
        end
        if (aciona_movimento && tipo_movimento) begin
          if (abort_at >= 0 && int'(move_idx) == abort_at) begin
            abortar = 1'b1;
            done    = 1'b1;
          end else begin
            sol_q.push_back(move_idx);
            fim_movimento = 1'b1;
          end
        end
        if (!done) @(negedge clock);
      end
    end
    ok = done;
  endtask

  initial begin
    int caps, caps_inv, repos, n;
    bit ok;
    reset = 1'b1; iniciar = 1'b0; abortar = 1'b0; num_movimentos = '0;
    clear_acks();
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check_eq("reset_outs", 32'(all_outs()), 32'd0);

    // Nominal: 6 faces, 3 solution moves.
    run_scan(-1, 0, 8'd3, -1, -1, caps, caps_inv, repos, ok);
    check_eq("nom_done", 32'(ok), 32'd1);
    check_eq("nom_caps", caps, 6);
    check_eq("nom_repos", repos, 6);
    check_eq("nom_sols", sol_q.size(), 3);
    for (int i = 0; i < 3; i++) begin
      if (sol_q.size() > i) check_eq($sformatf("nom_sol%0d", i), 32'(sol_q[i]), i);
    end
    check_eq("nom_pronto", 32'(pronto), 32'd1);
    check_eq("nom_db", 32'(db_estado), 32'hC);
    check_eq("nom_face", 32'(face_idx), 32'd5);

    // Face 2 invalid twice, then valid.
    run_scan(2, 2, 8'd3, -1, -1, caps, caps_inv, repos, ok);
    check_eq("retry_caps_f2", caps_inv, 3);
    check_eq("retry_caps", caps, 8);
    check_eq("retry_erro", 32'(erro), 32'd0);
    check_eq("retry_pronto", 32'(pronto), 32'd1);

    // Face 2 invalid three times: retries exhausted.
    run_scan(2, 3, 8'd3, -1, -1, caps, caps_inv, repos, ok);
    check_eq("exh_caps_f2", caps_inv, 3);
    check_eq("exh_erro", 32'(erro), 32'd1);
    check_eq("exh_code", 32'(err_code), 32'd2);
    check_eq("exh_db", 32'(db_estado), 32'hD);

    // ERRO -> iniciar -> PREPARA; then let CAPTURA time out.
    @(negedge clock); iniciar = 1'b1;
    @(negedge clock); iniciar = 1'b0;
    check_eq("rec_db", 32'(db_estado), 32'h1);
    check_eq("rec_code", 32'(err_code), 32'd0);
    @(negedge clock);
    check_eq("to_in_captura", 32'(db_estado), 32'h2);
    n = 0;
    while (db_estado == 4'h2 && n < 40) begin
      @(negedge clock);
      n++;
    end
    check_eq("to_cycles", n, 16);
    check_eq("to_db", 32'(db_estado), 32'hD);
    check_eq("to_code", 32'(err_code), 32'd1);
    iniciar = 1'b1;
    @(negedge clock); iniciar = 1'b0;
    check_eq("to_rec_db", 32'(db_estado), 32'h1);
    check_eq("to_rec_code", 32'(err_code), 32'd0);
    abortar = 1'b1;
    @(negedge clock); abortar = 1'b0;
    check_eq("abort_idle", 32'(db_estado), 32'h0);

    // Empty solution goes straight to FIM.
    run_scan(-1, 0, 8'd0, -1, -1, caps, caps_inv, repos, ok);
    check_eq("zero_sols", sol_q.size(), 0);
    check_eq("zero_pronto", 32'(pronto), 32'd1);
    check_eq("zero_repos", repos, 6);

    // Abort during MOVIMENTA at move 5.
    run_scan(-1, 0, 8'd8, 5, -1, caps, caps_inv, repos, ok);
    check_eq("abort_hit", 32'(ok && abortar), 32'd1);
    check_eq("abort_sols", sol_q.size(), 5);
    @(negedge clock); abortar = 1'b0;
    check_eq("abort_db", 32'(db_estado), 32'h0);
    check_eq("abort_move", 32'(move_idx), 32'd0);
    check_eq("abort_face", 32'(face_idx), 32'd0);

    // Reset during REPOSICIONA.
    run_scan(-1, 0, 8'd3, -1, 5, caps, caps_inv, repos, ok);
    check_eq("rst_reached", 32'(db_estado), 32'h5);
    reset = 1'b1;
    #2;
    check_eq("rst_no_edge", 32'(db_estado), 32'h5);
    @(negedge clock);
    check_eq("rst_outs", 32'(all_outs()), 32'd0);
    reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cube_scan_solve_uc.md
Name: cube_scan_solve_uc

Overview:
- Parametrised control unit for the next-generation Rubik's robot. Sequences face scanning (capture, identify, transmit, reposition) and then solution execution.
- Generalises the first-generation control unit:
  - face and move counters are internal;
  - per-transition reposition move counts come from a table;
  - identification failures are retried;
  - every wait state has a watchdog timeout;
  - an abort input is honoured.
- Sits between the host/serial link, the camera/colour datapath and the motor sequencer.

Parameters:
- N_FACES, 6, number of faces scanned (2..6).
- MOV_W, 8, width of the solution move count and move index.
- TIMEOUT_CYC, 50_000_000, cycles allowed in any wait state before error (≥2).
- TO_W, 26, width of the watchdog counter (must hold TIMEOUT_CYC-1).
- MAX_RETRY, 2, re-captures allowed per face after cores_invalidas (0..3).

Ports:
- clock in 1 system clock, rising edge.
- reset in 1 synchronous, active-high.
- iniciar in 1 start scan; also clears ERRO.
- abortar in 1 return to INICIAL from any state.
- imagem_recebida in 1 camera frame captured.
- cores_identificadas in 1 colour identification finished.
- cores_invalidas in 1 qualifies cores_identificadas: the result is invalid.
- cores_transmitidas in 1 face colours sent to host.
- movimentos_recebidos in 1 solution received; qualifies num_movimentos.
- num_movimentos in MOV_W solution length.
- fim_movimento in 1 motor sequencer finished the current move.
- captura_imagem out 1 request frame capture.
- identificar_cores out 1 run colour identification.
- enviar_cores out 1 transmit face colours.
- receber_movimentos out 1 waiting on host solution.
- aciona_movimento out 1 execute a move.
- tipo_movimento out 1 0 = reposition move, 1 = solution move.
- face_idx out 3 current face (0..N_FACES-1).
- move_idx out MOV_W index of the current move (reposition or solution).
- pronto out 1 solution complete.
- erro out 1 error state.
- err_code out 2 01 = timeout, 10 = retries exhausted, 00 = none.
- db_estado out 4 state encoding.

Behaviour:
- Clock and reset: single clock `clock`; synchronous active-high `reset` forces INICIAL and clears all counters and err_code. All outputs then read 0, and db_estado reads 0000.
- Output style: Moore decode of the registered state. Counters and err_code are registered.
- State encodings: INICIAL 0000, PREPARA 0001, CAPTURA 0010, IDENTIFICA 0011, TRANSMITE 0100, REPOSICIONA 0101, CONTA_REPOS 0110, PROX_FACE 0111, RECEBE_MOV 1000, PREPARA_MOV 1001, MOVIMENTA 1010, CONTA_MOV 1011, FIM 1100, ERRO 1101. Any illegal encoding goes to INICIAL, with db_estado reading 1111.
- Transitions:
  - INICIAL→PREPARA on iniciar.
  - PREPARA clears face_idx, move_idx and retries, then goes to CAPTURA.
  - CAPTURA→IDENTIFICA on imagem_recebida.
  - IDENTIFICA, on cores_identificadas:
    - valid → TRANSMITE and retry count cleared;
    - invalid with retry < MAX_RETRY → CAPTURA and retry+1;
    - otherwise → ERRO with err_code 10.
  - TRANSMITE, on cores_transmitidas: face_idx == N_FACES-1 → RECEBE_MOV, else → REPOSICIONA with move_idx = 0.
  - REPOSICIONA (aciona_movimento=1, tipo_movimento=0) → CONTA_REPOS on fim_movimento.
  - CONTA_REPOS increments move_idx. If move_idx+1 == REPOS_MOVES[face_idx] → PROX_FACE, else → REPOSICIONA.
  - PROX_FACE: face_idx+1, then CAPTURA.
  - RECEBE_MOV → PREPARA_MOV on movimentos_recebidos, latching num_movimentos.
  - PREPARA_MOV clears move_idx. Latched count 0 → FIM directly, else → MOVIMENTA.
  - MOVIMENTA (tipo_movimento=1) → CONTA_MOV on fim_movimento.
  - CONTA_MOV: move_idx+1 == count → FIM, else move_idx+1 and back to MOVIMENTA.
  - FIM → PREPARA on iniciar.
  - ERRO holds until iniciar, which clears err_code and goes to PREPARA.
- Watchdog:
  - Counts every cycle spent in the wait states CAPTURA, IDENTIFICA, TRANSMITE, REPOSICIONA, RECEBE_MOV and MOVIMENTA.
  - Reloads to 0 on every state change.
  - Reaching TIMEOUT_CYC-1 with the awaited input low → ERRO with err_code 01.
  - If the awaited input is high in that same cycle, the normal transition wins.
- abortar: highest priority below reset; → INICIAL next cycle, counters cleared.
- Simultaneous iniciar and abortar: abortar wins.

Decomposition:
- Package cube_uc_pkg holds:
  - the state encoding localparams;
  - the err_code values;
  - REPOS_MOVES table, 5 entries of 2 bits, default {1,1,1,2,1}.
- Sub-module uc_watchdog (parametrised TIMEOUT_CYC/TO_W counter with clear and expire outputs) is natural.
- Everything else stays in this module.

Test Plan:
- N_FACES=6, all acks given 1 cycle after request, num_movimentos=3 → 6 captures, 6 reposition moves in total, 3 solution moves with move_idx 0,1,2, then pronto=1 and db_estado=1100.
- cores_invalidas on face 2, twice then valid (MAX_RETRY=2) → 3 captures on face 2, no error. A third invalid → erro=1, err_code=10.
- TIMEOUT_CYC=16, imagem_recebida held low → ERRO entered exactly 16 cycles after entering CAPTURA, err_code=01. Then iniciar → PREPARA and err_code=00.
- num_movimentos=0 → PREPARA_MOV→FIM with aciona_movimento never asserting in the solution phase.
- abortar asserted mid-MOVIMENTA with move_idx=5 → INICIAL next cycle, move_idx=0, face_idx=0.
- reset asserted during REPOSICIONA → next edge db_estado=0000 and all outputs 0. No state change without a clock edge.
